// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register window layout,
// FSM state encoding and the bus address decoder.
package interrupt_controller_pkg;

    localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hF8;

    localparam logic [1:0] OFF_ENABLE   = 2'd0;
    localparam logic [1:0] OFF_PENDING  = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_RESERVED = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RAISE   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    typedef struct packed {
        logic       hit;
        logic [1:0] offset;
    } reg_sel_t;

    // Modular subtraction keeps the window check correct even when the
    // window sits at the very top of the address space.
    function automatic reg_sel_t decode_addr(input logic [7:0] addr,
                                             input logic [7:0] base);
        logic [7:0] diff;
        diff                = addr - base;
        decode_addr.hit     = (diff[7:2] == 6'd0);
        decode_addr.offset  = diff[1:0];
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Processor-side bus and interrupt handshake of the interrupt controller.
// BUS_DATA is a tristate net and lives on the top-level port instead.
interface interrupt_controller_if;

    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       INT_RAISE;
    logic       INT_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output INT_ACK,
        input  INT_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  INT_ACK,
        output INT_RAISE
    );

endinterface

// File: rtl/irq_priority_encoder.sv
// Combinational source selection: reports whether any request is set and
// the index of the lowest set request (index 0 has the highest priority).
module irq_priority_encoder (
    input  logic [3:0] req,
    output logic       valid,
    output logic [1:0] id
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = |req;
        id    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) id = 2'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller with a memory-mapped register window,
// one-at-a-time raise/acknowledge handshake and a one-cycle holdoff.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int         NUM_SRC   = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NUM_SRC-1:0]    IRQ_IN,
    inout  wire  [7:0]            BUS_DATA,
    interrupt_controller_if.slave bus
);

    logic [1:0]         state_q;
    logic [1:0]         id_q;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] pending_q;
    logic               rd_oe_q;
    logic [7:0]         rd_data_q;

    reg_sel_t           sel;
    logic               wr_fire;
    logic               rd_fire;
    logic               ack_fire;
    logic               int_raise;
    logic [NUM_SRC-1:0] ack_mask;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] eligible;
    logic               enc_valid;
    logic [1:0]         enc_id;
    logic [7:0]         read_val;
    logic               unused_bus_hi;

    assign sel       = decode_addr(bus.BUS_ADDR, BASE_ADDR);
    assign wr_fire   = sel.hit &  bus.BUS_WE;
    assign rd_fire   = sel.hit & ~bus.BUS_WE;
    assign int_raise = (state_q == ST_RAISE);
    assign ack_fire  = int_raise & bus.INT_ACK;

    assign bus.INT_RAISE = int_raise;

    // Only the low nibble of a write carries register data.
    assign unused_bus_hi = ^BUS_DATA[7:NUM_SRC];

    assign w1c_mask = (wr_fire && sel.offset == OFF_PENDING) ? BUS_DATA[NUM_SRC-1:0] : '0;
    assign ack_mask = ack_fire ? (NUM_SRC'(1) << id_q) : '0;
    assign eligible = pending_q & enable_q;

    irq_priority_encoder u_priority_encoder (
        .req   (eligible),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_ff @(posedge CLK) begin
        // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            if (wr_fire && sel.offset == OFF_ENABLE) enable_q <= BUS_DATA[NUM_SRC-1:0];
            // A new request on the same edge wins over any clear.
            pending_q <= (pending_q & ~(w1c_mask | ack_mask)) | IRQ_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            id_q    <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enc_valid) begin
                        state_q <= ST_RAISE;
                        id_q    <= enc_id;
                    end
                end
                // Once raised, only an acknowledge retracts the request.
                ST_RAISE:   if (bus.INT_ACK) state_q <= ST_HOLDOFF;
                ST_HOLDOFF: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        read_val = 8'h00;
        case (sel.offset)
            OFF_ENABLE:   read_val = 8'(enable_q);
            OFF_PENDING:  read_val = 8'(pending_q);
            OFF_STATUS:   read_val = {int_raise, 5'b0, id_q};
            OFF_RESERVED: read_val = 8'h00;
            default:      read_val = 8'h00;
        endcase
    end

    // Read data is captured at the addressing edge and driven for one cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_oe_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            rd_oe_q <= rd_fire;
            if (rd_fire) rd_data_q <= read_val;
        end
    end

    assign BUS_DATA = rd_oe_q ? rd_data_q : 8'bzzzz_zzzz;

endmodule
